// File: rtl/cpu_run_pkg.sv
// Shared types and stop-cause codes for the CPU run/step controller.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } run_state_e;

  localparam logic [1:0] STOP_COUNT = 2'b00;
  localparam logic [1:0] STOP_HALT  = 2'b01;
  localparam logic [1:0] STOP_CPU   = 2'b10;
  localparam logic [1:0] STOP_ZERO  = 2'b11;

  // External Halt outranks the CPU's own halt; either outranks count expiry.
  function automatic logic [1:0] end_cause(input logic halt, input logic cpu_halted);
    if (halt)            return STOP_HALT;
    else if (cpu_halted) return STOP_CPU;
    else                 return STOP_COUNT;
  endfunction

endpackage

// File: rtl/run_down_counter.sv
// Remaining-cycles down-counter: loads a length, decrements on enable, flags zero.
module run_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_controller.sv
// Gates the CPU clock-enable for a bounded run, a single step, or until halted,
// then pulses Done with the stop cause and the number of enabled cycles.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int CYCLE_W     = 8,
  parameter int DEFAULT_LEN = 30
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Start,
  input  logic               Step,
  input  logic               Halt,
  input  logic               UseDefault,
  input  logic [CYCLE_W-1:0] RunLen,
  input  logic               CpuHalted,
  output logic               CpuEnable,
  output logic               Busy,
  output logic               Done,
  output logic [1:0]         StopCause,
  output logic [CYCLE_W-1:0] CycleCount
);

  run_state_e         state_q;
  logic               cpu_enable_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         stop_cause_q;
  logic [CYCLE_W-1:0] cycle_count_q;

  logic [CYCLE_W-1:0] eff_len;
  logic [CYCLE_W-1:0] rem_cnt;
  logic [CYCLE_W-1:0] cycle_inc;
  logic               rem_zero;
  logic               cnt_load;
  logic               cnt_dec;
  logic               run_last;

  assign eff_len   = ((RunLen == '0) && UseDefault) ? CYCLE_W'(DEFAULT_LEN) : RunLen;
  assign cycle_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CYCLE_W'(1);
  assign cnt_load  = (state_q == ST_IDLE) && Start;
  assign cnt_dec   = (state_q == ST_RUN);
  // The edge that consumes the last remaining cycle ends the run.
  assign run_last  = rem_zero || (rem_cnt == CYCLE_W'(1));

  run_down_counter #(.W(CYCLE_W)) u_remaining (
    .clk_i      (Clock),
    .rst_n_i    (ResetN),
    .load_i     (cnt_load),
    .load_val_i (eff_len),
    .dec_i      (cnt_dec),
    .cnt_o      (rem_cnt),
    .zero_o     (rem_zero)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_IDLE;
      cpu_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stop_cause_q  <= STOP_COUNT;
      cycle_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            cycle_count_q <= '0;
            if (eff_len == '0) begin
              state_q      <= ST_FINISH;
              done_q       <= 1'b1;
              stop_cause_q <= STOP_ZERO;
            end else begin
              state_q      <= ST_RUN;
              cpu_enable_q <= 1'b1;
              busy_q       <= 1'b1;
              stop_cause_q <= STOP_COUNT;
            end
          end else if (Step) begin
            state_q       <= ST_STEP;
            cpu_enable_q  <= 1'b1;
            busy_q        <= 1'b1;
            stop_cause_q  <= STOP_COUNT;
            cycle_count_q <= '0;
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_inc;
          if (Halt || CpuHalted || run_last) begin
            state_q      <= ST_FINISH;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            stop_cause_q <= end_cause(Halt, CpuHalted);
          end
        end
        ST_STEP: begin
          cycle_count_q <= cycle_inc;
          state_q       <= ST_FINISH;
          cpu_enable_q  <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          stop_cause_q  <= end_cause(Halt, CpuHalted);
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CpuEnable  = cpu_enable_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign StopCause  = stop_cause_q;
  assign CycleCount = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scoreboard bench for cpu_run_controller against a per-request outcome model.
module tb_cpu_run_controller;

  logic       clk = 1'b0;
  logic       ResetN;
  logic       Start, Step, Halt, UseDefault, CpuHalted;
  logic [7:0] RunLen;
  logic       CpuEnable, Busy, Done;
  logic [1:0] StopCause;
  logic [7:0] CycleCount;

  cpu_run_controller #(.CYCLE_W(8), .DEFAULT_LEN(30)) dut (
    .Clock      (clk),
    .ResetN     (ResetN),
    .Start      (Start),
    .Step       (Step),
    .Halt       (Halt),
    .UseDefault (UseDefault),
    .RunLen     (RunLen),
    .CpuHalted  (CpuHalted),
    .CpuEnable  (CpuEnable),
    .Busy       (Busy),
    .Done       (Done),
    .StopCause  (StopCause),
    .CycleCount (CycleCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_en;
    int cause;
    int count;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of one request from the rules: the earliest of Halt, CpuHalted or
  // count expiry ends it, Halt winning ties, and every enabled cycle is counted.
  function automatic exp_t model(input bit is_step, input int len, input bit ud,
                                 input int ph, input int pc);
    exp_t e;
    int   l, hp, cp, m;
    l  = is_step ? 1 : ((len == 0 && ud) ? 30 : len);
    hp = (ph >= 1 && ph <= l) ? ph : 1000;
    cp = (pc >= 1 && pc <= l) ? pc : 1000;
    if (l == 0) begin
      e.n_en  = 0;
      e.cause = 3;
    end else begin
      m = l;
      if (hp < m) m = hp;
      if (cp < m) m = cp;
      e.n_en  = m;
      e.cause = (m == hp) ? 1 : ((m == cp) ? 2 : 0);
    end
    e.count    = (e.n_en > 255) ? 255 : e.n_en;
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic idle_inputs();
    Start = 0; Step = 0; Halt = 0; CpuHalted = 0; UseDefault = 0; RunLen = '0;
  endtask

  // ph/pc: enabled-cycle index (1-based) where Halt/CpuHalted is raised, 0 = never.
  task automatic do_req(input bit is_step, input int len, input bit ud,
                        input int ph, input int pc, input bit both);
    exp_t e;
    @(negedge clk);
    e = model(is_step, len, ud, ph, pc);
    e.done_cyc = cyc + 1 + e.n_en;
    sb.push_back(e);
    Start      = !is_step;
    Step       = is_step || both;
    RunLen     = 8'(len);
    UseDefault = ud;
    Halt       = 1'($urandom_range(0, 1));
    CpuHalted  = 1'($urandom_range(0, 1));
    for (int i = 1; i <= e.n_en + 1; i++) begin
      @(negedge clk);
      Start      = ($urandom_range(0, 3) == 0);
      Step       = ($urandom_range(0, 3) == 0);
      RunLen     = 8'($urandom_range(0, 255));
      UseDefault = 1'($urandom_range(0, 1));
      if (i == e.n_en + 1) begin
        Halt      = 1'($urandom_range(0, 1));
        CpuHalted = 1'($urandom_range(0, 1));
      end else begin
        Halt      = (i == ph);
        CpuHalted = (i == pc);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(CpuEnable),  0);
    chk({tag, "_busy"},  32'(Busy),       0);
    chk({tag, "_done"},  32'(Done),       0);
    chk({tag, "_cause"}, 32'(StopCause),  0);
    chk({tag, "_count"}, 32'(CycleCount), 0);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    Start = 1; RunLen = 8'd20;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    ResetN = 0;
    #1;
    chk_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    ResetN = 1;
  endtask

  // Monitor: counts enabled cycles and checks each Done against the scoreboard.
  initial begin
    int   en_cnt;
    exp_t e;
    en_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!ResetN) begin
        en_cnt = 0;
      end else begin
        chk("busy_vs_enable", 32'(Busy), 32'(CpuEnable));
        if (CpuEnable === 1'b1) en_cnt++;
        if (Done === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            chk("enabled_cycles", 32'(en_cnt),     32'(e.n_en));
            chk("stop_cause",     32'(StopCause),  32'(e.cause));
            chk("cycle_count",    32'(CycleCount), 32'(e.count));
            chk("done_cycle",     32'(cyc),        32'(e.done_cyc));
            chk("en_in_done",     32'(CpuEnable),  0);
          end
          en_cnt = 0;
        end
      end
    end
  end

  initial begin
    bit   st;
    int   len, r;
    idle_inputs();
    ResetN = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    ResetN = 1;

    do_req(0, 30, 0, 0, 0, 0);
    do_req(0, 0, 1, 0, 0, 0);
    do_req(0, 0, 0, 0, 0, 0);
    do_req(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    do_req(1, 0, 0, 0, 0, 0);
    do_req(0, 10, 0, 4, 0, 0);
    do_req(0, 10, 0, 0, 4, 0);
    do_req(0, 10, 0, 4, 4, 0);
    do_req(0, 10, 0, 10, 0, 0);
    do_req(0, 10, 0, 0, 10, 0);
    do_req(1, 0, 0, 1, 0, 0);
    do_req(1, 0, 0, 0, 1, 0);
    do_reset_mid();
    do_req(0, 20, 0, 0, 0, 0);
    do_req(0, 255, 0, 0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      st = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      len = (r == 0) ? 0 : ((r == 9) ? $urandom_range(200, 255) : $urandom_range(1, 40));
      if (st) len = 0;
      do_req(st, len, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, len + 2) : 0,
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, len + 2) : 0,
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("pending_done_at_end", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable run/step controller for the 24-bit CPU: gates the CPU's clock-enable for a programmed number of cycles, a single step, or until halted, then reports completion and cause. Sits between the board-level control inputs (buttons or debug host) and the CPU's enable input, so the bounded-run behaviour used in simulation is also available in hardware. Owns no CPU state; it only decides in which cycles the CPU advances.

## Interface
Parameters:
- CYCLE_W, 8, width of run length and cycle counter
- DEFAULT_LEN, 30, run length used when RunLen is 0 and UseDefault is 1

Ports:
- Clock  in  1  single system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  request bounded run, sampled on Clock
- Step  in  1  request exactly one CPU cycle
- Halt  in  1  external abort of current run
- UseDefault  in  1  substitute DEFAULT_LEN when RunLen is 0
- RunLen  in  CYCLE_W  number of CPU cycles to run, latched on accepted Start
- CpuHalted  in  1  CPU reports halt instruction executed
- CpuEnable  out  1  registered enable to CPU; CPU advances only when 1
- Busy  out  1  high in RUN or STEP
- Done  out  1  one-cycle completion pulse
- StopCause  out  2  00 count expired, 01 Halt, 10 CpuHalted, 11 zero-length; held until next accepted request
- CycleCount  out  CYCLE_W  enabled cycles in current/last run

## Operation
- States: IDLE, RUN, STEP, FINISH.
- IDLE: CpuEnable=0. Start accepted -> effective length L = RunLen, or DEFAULT_LEN if RunLen==0 and UseDefault. L!=0 -> RUN, remaining=L, CycleCount=0. L==0 -> FINISH, StopCause=11.
- Step in IDLE (no Start) -> STEP, CycleCount=0. Start and Step same cycle: Start wins, Step dropped.
- RUN: CpuEnable=1; each enabled cycle CycleCount+1, remaining-1. remaining reaches 0 -> FINISH, StopCause=00.
- Halt in RUN/STEP -> FINISH, StopCause=01. CpuHalted (seen while CpuEnable=1) -> FINISH, StopCause=10. Halt and CpuHalted together: 01. Halt/CpuHalted on last counted cycle: Halt/CpuHalted cause wins over 00.
- STEP: CpuEnable=1 one cycle -> FINISH, StopCause=00 (or 10 if CpuHalted).
- FINISH: Done=1 one cycle -> IDLE. Start/Step outside IDLE ignored (not queued).
- CycleCount saturates at 2^CYCLE_W-1; never wraps.

## Timing
- Reset (ResetN=0, immediate): state IDLE, CpuEnable=0, Busy=0, Done=0, StopCause=00, CycleCount=0, remaining=0. Reset mid-run drops CpuEnable without Done.
- Start sampled at edge k (L>0, no abort): CpuEnable high for exactly cycles k+1..k+L; Done high in cycle k+L+1; Busy high k+1..k+L.
- Step at edge k: CpuEnable high cycle k+1 only, Done cycle k+2.
- Halt sampled at edge j during RUN: CpuEnable low from j+1, Done in cycle j+1; CycleCount excludes cycle j+1.
- Zero-length Start at k: Done in k+1, CpuEnable never asserted.
- Back-to-back: Start in the Done cycle is ignored; earliest accepted at the cycle after Done.

## Structure
- Package cpu_run_pkg: state enum (IDLE, RUN, STEP, FINISH), StopCause constants (STOP_COUNT, STOP_HALT, STOP_CPU, STOP_ZERO).
- One sub-module: run_down_counter (load, decrement-on-enable, zero flag, CYCLE_W wide). FSM, CycleCount and output registers in top.

## Test plan
- Start with RunLen=30 -> CpuEnable exactly 30 cycles, Done 1 cycle later, StopCause=00, CycleCount=30.
- Start with RunLen=0, UseDefault=1 -> 30 enabled cycles; UseDefault=0 -> Done next cycle, StopCause=11, no enable.
- Step twice, separated by idle -> two single enable pulses, two Done pulses, CycleCount=1 each.
- RunLen=10, Halt at 4th enabled cycle -> 4 enabled cycles, Done, StopCause=01; CpuHalted instead -> StopCause=10.
- ResetN low at 5th enabled cycle of 20 -> all outputs zero immediately, no Done; new Start after release runs full length.
- RunLen=255 with CYCLE_W=8, Start and Step same cycle -> Step dropped, CycleCount=255 saturated, Start during RUN ignored.
